cdb_arbiter: RTL and testbench

Shares the single common data bus (CDB) among the out-of-order core's functional units (ALU, multiplier, divider, LSU).
- Each FU hands off a completed result through a one-entry holding slot using a valid/ready handshake.
- A round-robin scheduler grants one slot per cycle.
- The winner is driven onto a registered cdb_t that feeds the ROB, the reservation stations and the physical register file.
- A flush input discards all in-flight results on mispredict.

---
 rtl/rv32i_types.sv | 35 +++
 rtl/cdb_rr_pick.sv | 31 +++
 rtl/cdb_arbiter.sv | 124 ++++++++++++
 tb/tb_cdb_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared core types: CDB broadcast record, functional-unit ids and a
// round-robin index helper used by the CDB arbiter.
package rv32i_types;

  localparam int XLEN       = 32;
  localparam int ROB_IDX_W  = 6;
  localparam int PREG_W     = 6;
  localparam int AREG_W     = 5;
  localparam int NUM_CDB_FU = 4;

  // 82-bit result record carried on the common data bus.
  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [PREG_W-1:0]    pd_s;
    logic [AREG_W-1:0]    rd_s;
    logic [XLEN-1:0]      rd_v;
    logic                 valid;
    logic [31:0]          inst;
  } cdb_t;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_MUL = 2'd1,
    FU_DIV = 2'd2,
    FU_LSU = 2'd3
  } fu_id_t;

  // (base + off) wrapped into [0, n); base < n and off < n.
  function automatic int rr_wrap(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/cdb_rr_pick.sv
// Purely combinational round-robin picker: first requester at or after ptr_i,
// wrapping from the top index back to 0.
module cdb_rr_pick
  import rv32i_types::*;
#(
  parameter  int NUM_FU = NUM_CDB_FU,
  localparam int IDX_W  = $clog2(NUM_FU)
) (
  input  logic [NUM_FU-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NUM_FU-1:0] win_o,
  output logic [IDX_W-1:0]  win_idx_o,
  output logic              any_o
);

  // NOTE: every output gets a default before the search so no path leaves
  // a variable unassigned, which would infer a latch.
  always_comb begin
    win_o     = '0;
    win_idx_o = '0;
    any_o     = 1'b0;
    for (int off = 0; off < NUM_FU; off++) begin
      if (!any_o && req_i[rr_wrap(int'(ptr_i), off, NUM_FU)]) begin
        win_o[rr_wrap(int'(ptr_i), off, NUM_FU)] = 1'b1;
        win_idx_o = IDX_W'(rr_wrap(int'(ptr_i), off, NUM_FU));
        any_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one holding slot per FU, round-robin grant, registered broadcast.
// Optional CDB_ARB_PERF_EN adds per-FU stall counters and a broadcast counter.
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter  int NUM_FU   = NUM_CDB_FU,
  localparam int FU_IDX_W = $clog2(NUM_FU)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  cdb_t [NUM_FU-1:0]       fu_result,
  output logic [NUM_FU-1:0]       fu_ready,
  output cdb_t                    cdb_out,
  output logic [FU_IDX_W-1:0]     grant_idx
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [NUM_FU-1:0][31:0] perf_stall_cnt,
  output logic [31:0]             perf_bcast_cnt
`endif
);

  logic [NUM_FU-1:0]   hold_v_q, hold_v_d;
  cdb_t [NUM_FU-1:0]   hold_data_q, hold_data_d;
  logic [FU_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  cdb_t                cdb_q, cdb_d;
  logic [FU_IDX_W-1:0] grant_q, grant_d;

  logic [NUM_FU-1:0]   win;
  logic [FU_IDX_W-1:0] win_idx;
  logic                any_win;
  logic [NUM_FU-1:0]   accept;

  cdb_rr_pick #(.NUM_FU(NUM_FU)) u_pick (
    .req_i     (hold_v_q),
    .ptr_i     (rr_ptr_q),
    .win_o     (win),
    .win_idx_o (win_idx),
    .any_o     (any_win)
  );

  // A slot draining this cycle can refill in the same cycle.
  assign fu_ready = ~hold_v_q | win;

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      accept[i] = fu_result[i].valid && fu_ready[i];
    end
  end

  always_comb begin
    hold_v_d    = hold_v_q;
    hold_data_d = hold_data_q;
    rr_ptr_d    = rr_ptr_q;
    cdb_d       = cdb_q;
    cdb_d.valid = 1'b0;
    grant_d     = grant_q;
    if (flush) begin
      hold_v_d = '0;
    end else begin
      if (any_win) begin
        cdb_d    = hold_data_q[win_idx];
        grant_d  = win_idx;
        rr_ptr_d = (int'(win_idx) == NUM_FU - 1) ? '0 : win_idx + 1'b1;
      end
      hold_v_d = (hold_v_q & ~win) | accept;
      for (int i = 0; i < NUM_FU; i++) begin
        if (accept[i]) begin
          hold_data_d[i]       = fu_result[i];
          hold_data_d[i].valid = 1'b1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_v_q    <= '0;
      // NOTE: the slot payloads are cleared too so a fresh reset leaves no
      // stale result data anywhere in the block.
      hold_data_q <= '0;
      rr_ptr_q    <= '0;
      cdb_q       <= '0;
      grant_q     <= '0;
    end else begin
      hold_v_q    <= hold_v_d;
      hold_data_q <= hold_data_d;
      rr_ptr_q    <= rr_ptr_d;
      cdb_q       <= cdb_d;
      grant_q     <= grant_d;
    end
  end

  assign cdb_out   = cdb_q;
  assign grant_idx = grant_q;

`ifdef CDB_ARB_PERF_EN
  logic [NUM_FU-1:0][31:0] stall_cnt_q;
  logic [31:0]             bcast_cnt_q;

  // Counters saturate and survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      bcast_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (hold_v_q[i] && !win[i] && !flush && (stall_cnt_q[i] != '1)) begin
          stall_cnt_q[i] <= stall_cnt_q[i] + 32'd1;
        end
      end
      if (any_win && !flush && (bcast_cnt_q != '1)) begin
        bcast_cnt_q <= bcast_cnt_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_bcast_cnt = bcast_cnt_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: slot/queue model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_cdb_arbiter;
  import rv32i_types::*;

  localparam int N = NUM_CDB_FU;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  cdb_t [N-1:0] fu_result;
  logic [N-1:0] fu_ready;
  cdb_t       cdb_out;
  logic [1:0] grant_idx;
`ifdef CDB_ARB_PERF_EN
  logic [N-1:0][31:0] perf_stall_cnt;
  logic [31:0]        perf_bcast_cnt;
`endif

  always #5 clk = ~clk;

  cdb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .fu_result (fu_result),
    .fu_ready  (fu_ready),
    .cdb_out   (cdb_out),
    .grant_idx (grant_idx)
`ifdef CDB_ARB_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_bcast_cnt (perf_bcast_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  cdb_t m_slot [N];
  bit   m_full [N];
  bit   m_acc  [N];
  int   m_stall[N];
  int   m_next;
  cdb_t m_cdb;
  int   m_grant;
  int   m_bcast;
  bit   model_live = 1'b0;

  // Winner = first full slot scanning upward from the pointer, with wrap.
  function automatic int m_pick();
    for (int off = 0; off < N; off++) begin
      if (m_full[(m_next + off) % N]) return (m_next + off) % N;
    end
    return -1;
  endfunction

  task automatic model_step();
    int w;
    w = m_pick();
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        m_full[i] = 1'b0; m_slot[i] = '0; m_acc[i] = 1'b0; m_stall[i] = 0;
      end
      m_cdb = '0; m_grant = 0; m_next = 0; m_bcast = 0;
      model_live = 1'b1;
    end else begin
      for (int i = 0; i < N; i++) begin
        m_acc[i] = fu_result[i].valid && (!m_full[i] || w == i);
      end
      if (flush) begin
        for (int i = 0; i < N; i++) m_full[i] = 1'b0;
        m_cdb.valid = 1'b0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (m_full[i] && w != i) m_stall[i]++;
        end
        if (w >= 0) begin
          m_cdb   = m_slot[w];
          m_grant = w;
          m_next  = (w + 1) % N;
          m_full[w] = 1'b0;
          m_bcast++;
        end else begin
          m_cdb.valid = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
          if (m_acc[i]) begin
            m_slot[i] = fu_result[i];
            m_slot[i].valid = 1'b1;
            m_full[i] = 1'b1;
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  logic [N-1:0] cmp_rdy;
  int           cmp_w;

  initial forever begin
    @(negedge clk);
    if (model_live) begin
      cmp_w = m_pick();
      for (int i = 0; i < N; i++) cmp_rdy[i] = !m_full[i] || (cmp_w == i);
      check("model_fu_ready", fu_ready, cmp_rdy);
      check("model_cdb_valid", cdb_out.valid, m_cdb.valid);
      if (m_cdb.valid) begin
        check("model_cdb_payload", cdb_out, m_cdb);
        check("model_grant_idx", grant_idx, m_grant);
      end
`ifdef CDB_ARB_PERF_EN
      for (int i = 0; i < N; i++) check("model_perf_stall", perf_stall_cnt[i], m_stall[i]);
      check("model_perf_bcast", perf_bcast_cnt, m_bcast);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic cdb_t mk(input int rob, input int pd, input int rd,
                              input logic [31:0] val, input logic [31:0] ins);
    cdb_t r;
    r.rob_idx = ROB_IDX_W'(rob);
    r.pd_s    = PREG_W'(pd);
    r.rd_s    = AREG_W'(rd);
    r.rd_v    = val;
    r.valid   = 1'b1;
    r.inst    = ins;
    return r;
  endfunction

  // Advance one edge; an FU drops its valid once the transfer happened.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (m_acc[i]) fu_result[i].valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    flush = 1'b0;
    fu_result = '0;
    step();
    step();
    rst = 1'b1;
  endtask

  int r;

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    fu_result = '0;

    // Reset then idle.
    do_reset();
    check("rst_fu_ready", fu_ready, 4'b1111);
    check("rst_cdb_valid", cdb_out.valid, 1'b0);
    check("rst_grant_idx", grant_idx, 2'd0);
    check("rst_rr_ptr", dut.rr_ptr_q, 2'd0);

    // Single ALU result, rd_s = 0 still broadcast.
    fu_result[int'(FU_ALU)] = mk(5, 12, 0, 32'hDEADBEEF, 32'h0000_0013);
    step();
    check("alu_not_same_edge", cdb_out.valid, 1'b0);
    step();
    check("alu_valid", cdb_out.valid, 1'b1);
    check("alu_rob_idx", cdb_out.rob_idx, 6'd5);
    check("alu_pd_s", cdb_out.pd_s, 6'd12);
    check("alu_rd_s", cdb_out.rd_s, 5'd0);
    check("alu_rd_v", cdb_out.rd_v, 32'hDEADBEEF);
    check("alu_grant", grant_idx, 2'd0);
    check("alu_rr_ptr", dut.rr_ptr_q, 2'd1);
    step();
    check("alu_valid_drop", cdb_out.valid, 1'b0);

    // All four FUs at once, strict rotation from pointer 0.
    do_reset();
    for (int i = 0; i < N; i++) fu_result[i] = mk(i + 1, 20 + i, i + 1, 32'h1000 + i, 32'h0);
    step();
    check("all4_lsu_wait", fu_ready[3], 1'b0);
    for (int k = 0; k < N; k++) begin
      step();
      check("all4_valid", cdb_out.valid, 1'b1);
      check("all4_grant", grant_idx, k);
      check("all4_rob_idx", cdb_out.rob_idx, k + 1);
      check("all4_lsu_ready", fu_ready[3], k >= 2);
    end
    step();
    check("all4_drained", cdb_out.valid, 1'b0);

    // Continuous MUL and DIV streams alternate.
    do_reset();
    r = 32;
    fu_result[int'(FU_MUL)] = mk(r, r, 1, 32'hA000 + r, 32'h1); r++;
    fu_result[int'(FU_DIV)] = mk(r, r, 2, 32'hB000 + r, 32'h2); r++;
    step();
    for (int k = 0; k < 8; k++) begin
      for (int i = 1; i <= 2; i++) begin
        if (!fu_result[i].valid) begin
          fu_result[i] = mk(r, r, i, 32'hC000 + r, 32'h3);
          r++;
        end
      end
      step();
      check("muldiv_valid", cdb_out.valid, 1'b1);
      check("muldiv_grant", grant_idx, (k % 2 == 0) ? 1 : 2);
    end
    fu_result = '0;
    step();
    step();

    // Flush with MUL and LSU held while a new ALU result is presented.
    do_reset();
    fu_result[0] = mk(3, 3, 3, 32'h33, 32'h0);
    fu_result[1] = mk(7, 7, 7, 32'h77, 32'h0);
    fu_result[3] = mk(9, 9, 9, 32'h99, 32'h0);
    step();
    step();
    check("pre_flush_valid", cdb_out.valid, 1'b1);
    check("pre_flush_grant", grant_idx, 2'd0);
    fu_result[0] = mk(11, 11, 11, 32'hBB, 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    fu_result = '0;
    check("flush_valid", cdb_out.valid, 1'b0);
    check("flush_rr_ptr", dut.rr_ptr_q, 2'd1);
    check("flush_ready", fu_ready, 4'b1111);
    for (int k = 0; k < 4; k++) begin
      step();
      check("flush_no_late_bcast", cdb_out.valid, 1'b0);
    end

`ifdef CDB_ARB_PERF_EN
    // Three slots held together: stall counts 0,1,2 and three broadcasts.
    do_reset();
    for (int i = 0; i < 3; i++) fu_result[i] = mk(40 + i, i, i, 32'h0, 32'h0);
    step();
    for (int k = 0; k < 4; k++) step();
    check("perf_stall0", perf_stall_cnt[0], 32'd0);
    check("perf_stall1", perf_stall_cnt[1], 32'd1);
    check("perf_stall2", perf_stall_cnt[2], 32'd2);
    check("perf_stall3", perf_stall_cnt[3], 32'd0);
    check("perf_bcast", perf_bcast_cnt, 32'd3);
`endif

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
